keypad_entry_ctrl: RTL and testbench
====================================

// Module: keypad_entry_ctrl
// PURPOSE
//  Sequencer downstream of keypad_scan: turns its row/col/valid strobes into single key events.
//  - Repeat suppression: one event per physical press.
//  - Assembles two BCD operands (A then B), hands the pair to the arithmetic stage via valid/ready.
//  - Drives a display value showing the operand being entered.
// PARAMETERS
//  MAX_DIGITS      3        BCD digits per operand; operand width W = 4*MAX_DIGITS
//  RELEASE_CYCLES  500_000  cycles with key_valid=0 before the next key is accepted (>4 scan rows)
// PORTS
//  clk          in   1    single clock, all logic on posedge
//  rst_n        in   1    asynchronous active-low reset
//  key_row      in   2    row from keypad_scan
//  key_col      in   2    col from keypad_scan
//  key_valid    in   1    key_row/key_col qualifier from keypad_scan
//  key_stb      out  1    1-cycle pulse per accepted key
//  key_code     out  4    code of last accepted key
//  state        out  2    0=ENTER_A 1=ENTER_B 2=HANDOFF
//  disp_bcd     out  W    operand being entered (A in ENTER_A, B otherwise)
//  disp_digits  out  $clog2(MAX_DIGITS+1)  digit count of disp_bcd
//  op_a         out  W    BCD operand A, LS digit in [3:0]
//  op_b         out  W    BCD operand B
//  op_valid     out  1    operands stable and offered
//  op_ready     in   1    consumer accepts when op_valid&&op_ready
// BEHAVIOUR
//  Reset: state=ENTER_A; all outputs 0; armed=1; release counter 0.
//  Decode: code = map[row*4+col], where map = {1,2,3,A, 4,5,6,B, 7,8,9,C, *,0,#,D}.
//   Codes: digit n -> n; A..D -> 10..13; '*' -> 14; '#' -> 15.
//  Accept:
//   - key_valid && armed -> key_stb=1 next cycle, key_code updated, armed<=0.
//   - Any key_valid cycle clears the release counter.
//   - armed<=1 when the counter reaches RELEASE_CYCLES-1 with key_valid=0. The counter saturates.
//  ENTER_A:
//   - digit: if cnt<MAX_DIGITS, op_a<={op_a[W-5:0],digit} and cnt++. Else ignored.
//   - '#': with cnt>0 -> ENTER_B, digit count 0. With cnt=0, ignored.
//   - '*': op_a=0, cnt=0.
//  ENTER_B:
//   - digits as above into op_b.
//   - '#' with cnt>0 -> HANDOFF, op_valid=1 on the same edge.
//   - '*': op_a=op_b=0, counts 0 -> ENTER_A.
//  HANDOFF:
//   - op_valid held; op_a/op_b frozen.
//   - op_valid&&op_ready -> ENTER_A, op_valid=0, operands and counts cleared on the same edge.
//   - Keys are accepted (key_stb pulses, arming consumed) but do not change operands.
//   - A key arriving in the same cycle as the handshake is discarded.
//  A..C (and D unless KEY_BACKSPACE_EN) are accepted but have no effect.
//  Latency: key_valid edge -> key_stb plus operand update 1 cycle later; no combinational in->out paths.
//  Reset mid-entry or mid-handoff: immediate return to reset values; op_valid drops asynchronously.
// CONFIGURATION
//  KEY_BACKSPACE_EN defined:
//   - 'D' in ENTER_A/B with cnt>0: operand <= {4'h0,operand[W-1:4]}, cnt--.
//   - With cnt=0 in ENTER_B: -> ENTER_A, A and its count untouched.
//  Undefined: 'D' ignored like A..C.
// TESTING (MAX_DIGITS=3, RELEASE_CYCLES=8)
//  1 Reset -> state=0, op_valid=0, disp_bcd=0, key_stb=0.
//  2 Press 1,2,#,3,4,# with release gaps -> op_a=12'h012, op_b=12'h034, op_valid=1.
//    Then op_ready=1 for 1 cycle -> op_valid=0, state=0, op_a=0.
//  3 Hold key 5: key_valid pulses every 4 cycles for 40 cycles -> exactly one key_stb, op_a=12'h005.
//  4 Enter 9,8,7,6 -> op_a=12'h987, cnt=3; '#' with empty A -> no state change.
//  5 A=1,#, B=2, then '*' -> state=0, op_a=op_b=0.
//    In HANDOFF with op_ready=0, press 7 -> key_stb=1, operands unchanged.
//  6 (KEY_BACKSPACE_EN) 4,5,D -> op_a=12'h004.
//    '#',D in ENTER_B -> state=0, op_a=12'h004. Without the macro, D leaves op_a=12'h045.

Source files
------------

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: debounces keypad_scan strobes into single key events and assembles two BCD operands.
// Optional feature: define KEY_BACKSPACE_EN to make 'D' delete the last digit entered.
module keypad_entry_ctrl #(
  parameter  int MAX_DIGITS     = 3,
  parameter  int RELEASE_CYCLES = 500_000,
  localparam int W              = 4 * MAX_DIGITS,
  localparam int CW             = $clog2(MAX_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    key_row,
  input  logic [1:0]    key_col,
  input  logic          key_valid,
  output logic          key_stb,
  output logic [3:0]    key_code,
  output logic [1:0]    state,
  output logic [W-1:0]  disp_bcd,
  output logic [CW-1:0] disp_digits,
  output logic [W-1:0]  op_a,
  output logic [W-1:0]  op_b,
  output logic          op_valid,
  input  logic          op_ready
);

  localparam int RW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

  localparam logic [3:0] CODE_STAR = 4'd14;
  localparam logic [3:0] CODE_HASH = 4'd15;
`ifdef KEY_BACKSPACE_EN
  localparam logic [3:0] CODE_BKSP = 4'd13;
`endif

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    HANDOFF = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
  logic [CW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic          op_valid_q, op_valid_d;
  logic          armed_q;
  logic [RW-1:0] rel_cnt_q;
  logic          accept;
  logic [3:0]    code;
  logic          is_digit;

  // Physical layout {1,2,3,A, 4,5,6,B, 7,8,9,C, *,0,#,D} indexed by row*4+col.
  always_comb begin
    unique case ({key_row, key_col})
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = 4'd10;
      4'd4:    code = 4'd4;
      4'd5:    code = 4'd5;
      4'd6:    code = 4'd6;
      4'd7:    code = 4'd11;
      4'd8:    code = 4'd7;
      4'd9:    code = 4'd8;
      4'd10:   code = 4'd9;
      4'd11:   code = 4'd12;
      4'd12:   code = CODE_STAR;
      4'd13:   code = 4'd0;
      4'd14:   code = CODE_HASH;
      default: code = 4'd13;
    endcase
  end

  assign accept   = key_valid && armed_q;
  assign is_digit = (code <= 4'd9);

  always_comb begin
    // NOTE: every next-value gets a hold default first so no branch can infer a latch.
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    op_valid_d = op_valid_q;
    unique case (state_q)
      ENTER_A: if (accept) begin
        if (is_digit) begin
          if (cnt_a_q < CW'(MAX_DIGITS)) begin
            op_a_d  = (op_a_q << 4) | W'(code);
            cnt_a_d = cnt_a_q + CW'(1);
          end
        end else if (code == CODE_HASH) begin
          if (cnt_a_q != '0) begin
            state_d = ENTER_B;
            cnt_b_d = '0;
          end
        end else if (code == CODE_STAR) begin
          op_a_d  = '0;
          cnt_a_d = '0;
        end
`ifdef KEY_BACKSPACE_EN
        else if (code == CODE_BKSP && cnt_a_q != '0) begin
          op_a_d  = op_a_q >> 4;
          cnt_a_d = cnt_a_q - CW'(1);
        end
`endif
      end
      ENTER_B: if (accept) begin
        if (is_digit) begin
          if (cnt_b_q < CW'(MAX_DIGITS)) begin
            op_b_d  = (op_b_q << 4) | W'(code);
            cnt_b_d = cnt_b_q + CW'(1);
          end
        end else if (code == CODE_HASH) begin
          if (cnt_b_q != '0) begin
            state_d    = HANDOFF;
            op_valid_d = 1'b1;
          end
        end else if (code == CODE_STAR) begin
          state_d = ENTER_A;
          op_a_d  = '0;
          op_b_d  = '0;
          cnt_a_d = '0;
          cnt_b_d = '0;
        end
`ifdef KEY_BACKSPACE_EN
        else if (code == CODE_BKSP) begin
          if (cnt_b_q != '0) begin
            op_b_d  = op_b_q >> 4;
            cnt_b_d = cnt_b_q - CW'(1);
          end else begin
            state_d = ENTER_A;
          end
        end
`endif
      end
      HANDOFF: if (op_valid_q && op_ready) begin
        // A key landing on the handshake cycle is dropped: the clear takes priority.
        state_d    = ENTER_A;
        op_valid_d = 1'b0;
        op_a_d     = '0;
        op_b_d     = '0;
        cnt_a_d    = '0;
        cnt_b_d    = '0;
      end
      default: state_d = ENTER_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ENTER_A;
      op_a_q     <= '0;
      op_b_q     <= '0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      op_valid_q <= 1'b0;
      key_stb    <= 1'b0;
      key_code   <= '0;
      armed_q    <= 1'b1;
      rel_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      op_valid_q <= op_valid_d;
      key_stb    <= accept;
      if (accept) begin
        key_code <= code;
        armed_q  <= 1'b0;
      end
      if (key_valid) begin
        rel_cnt_q <= '0;
      end else if (rel_cnt_q == RW'(RELEASE_CYCLES - 1)) begin
        armed_q <= 1'b1;
      end else begin
        rel_cnt_q <= rel_cnt_q + RW'(1);
      end
    end
  end

  assign state       = state_q;
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign op_valid    = op_valid_q;
  assign disp_bcd    = (state_q == ENTER_A) ? op_a_q : op_b_q;
  assign disp_digits = (state_q == ENTER_A) ? cnt_a_q : cnt_b_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed self-checking bench for keypad_entry_ctrl with MAX_DIGITS=3, RELEASE_CYCLES=8.
module tb_keypad_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  key_row, key_col;
  logic        key_valid, op_ready;
  logic        key_stb;
  logic [3:0]  key_code;
  logic [1:0]  state;
  logic [11:0] disp_bcd, op_a, op_b;
  logic [1:0]  disp_digits;
  logic        op_valid;

  int n_cmp = 0;
  int n_err = 0;
  int stbs;

  keypad_entry_ctrl #(.MAX_DIGITS(3), .RELEASE_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .key_row(key_row), .key_col(key_col), .key_valid(key_valid),
    .key_stb(key_stb), .key_code(key_code), .state(state), .disp_bcd(disp_bcd),
    .disp_digits(disp_digits), .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Keypad position of each code, derived from the layout {1,2,3,A,4,5,6,B,7,8,9,C,*,0,#,D}.
  function automatic logic [3:0] pos_of(input int c);
    case (c)
      1: return 4'd0;   2: return 4'd1;   3: return 4'd2;   10: return 4'd3;
      4: return 4'd4;   5: return 4'd5;   6: return 4'd6;   11: return 4'd7;
      7: return 4'd8;   8: return 4'd9;   9: return 4'd10;  12: return 4'd11;
      14: return 4'd12; 0: return 4'd13;  15: return 4'd14; default: return 4'd15;
    endcase
  endfunction

  // One-cycle press, checks the strobe and decoded code, then waits out the release window.
  task automatic press(input int c);
    logic [3:0] p;
    p = pos_of(c);
    @(negedge clk);
    key_row = p[3:2];
    key_col = p[1:0];
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check("key_stb", 32'(key_stb), 32'd1);
    check("key_code", 32'(key_code), 32'(c));
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; key_row = '0; key_col = '0; key_valid = 1'b0; op_ready = 1'b0;
    #23;
    check("rst_state", 32'(state), 32'd0);
    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_disp", 32'(disp_bcd), 32'd0);
    check("rst_key_stb", 32'(key_stb), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic two-operand entry and handshake.
    press(1); press(2);
    check("disp_a", 32'(disp_bcd), 32'h012);
    check("digits_a", 32'(disp_digits), 32'd2);
    press(15);
    check("state_b", 32'(state), 32'd1);
    press(3); press(4); press(15);
    check("op_a", 32'(op_a), 32'h012);
    check("op_b", 32'(op_b), 32'h034);
    check("op_valid", 32'(op_valid), 32'd1);
    check("state_hand", 32'(state), 32'd2);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    check("hs_valid", 32'(op_valid), 32'd0);
    check("hs_state", 32'(state), 32'd0);
    check("hs_op_a", 32'(op_a), 32'h000);
    check("hs_op_b", 32'(op_b), 32'h000);

    // Held key with scan gaps shorter than the release window.
    stbs = 0;
    key_row = 2'd1; key_col = 2'd1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (key_stb) stbs++;
      key_valid = (i % 4 == 0);
    end
    key_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (key_stb) stbs++;
    end
    check("hold_stbs", 32'(stbs), 32'd1);
    check("hold_op_a", 32'(op_a), 32'h005);
    press(14);
    check("clear_a", 32'(op_a), 32'h000);

    // Digit overflow and '#' on empty A.
    press(9); press(8); press(7); press(6);
    check("ovf_op_a", 32'(op_a), 32'h987);
    check("ovf_digits", 32'(disp_digits), 32'd3);
    press(14); press(15);
    check("empty_hash", 32'(state), 32'd0);

    // '*' in ENTER_B abandons both operands.
    press(1); press(15); press(2); press(14);
    check("star_state", 32'(state), 32'd0);
    check("star_op_a", 32'(op_a), 32'h000);
    check("star_op_b", 32'(op_b), 32'h000);

    // Key during HANDOFF is strobed but does not touch operands.
    press(1); press(15); press(2); press(15);
    press(7);
    check("hand_op_a", 32'(op_a), 32'h001);
    check("hand_op_b", 32'(op_b), 32'h002);
    check("hand_state", 32'(state), 32'd2);

    // Asynchronous reset mid-handoff.
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(op_valid), 32'd0);
    check("arst_state", 32'(state), 32'd0);
    check("arst_op_a", 32'(op_a), 32'h000);
    @(negedge clk);
    rst_n = 1'b1;

    // 'D' key: backspace when enabled, ignored otherwise.
    press(4); press(5); press(13);
`ifdef KEY_BACKSPACE_EN
    check("bksp_op_a", 32'(op_a), 32'h004);
    press(15); press(13);
    check("bksp_state", 32'(state), 32'd0);
    check("bksp_keep_a", 32'(op_a), 32'h004);
`else
    check("d_op_a", 32'(op_a), 32'h045);
    press(15); press(13);
    check("d_state", 32'(state), 32'd1);
    check("d_keep_a", 32'(op_a), 32'h045);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
